// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the rx pin, frames each byte from an integer
// baud divider and reports it with a one-cycle valid or frame_err strobe.
module uart_rx #(
    parameter int unsigned BAUD = 9600,
    parameter int unsigned F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV   = F / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);

    typedef enum logic [1:0] {
        START = 2'b00,
        DATA  = 2'b01,
        STOP  = 2'b10,
        IDLE  = 2'b11
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               rx_m;
    logic               rx_s;
    logic               rx_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [2:0]         idx;
    logic [2:0]         idx_nxt;
    logic [7:0]         shift;
    logic [7:0]         shift_nxt;
    logic [7:0]         data_nxt;
    logic               valid_nxt;
    logic               frame_err_nxt;
    logic               busy_nxt;
    logic               half_hit;
    logic               bit_hit;
    logic               fall;

    assign half_hit = (cnt == CNT_W'(HALF - 1));
    assign bit_hit  = (cnt == CNT_W'(DIV - 1));
    assign fall     = rx_d & ~rx_s;

    // Two-flop synchronizer plus one delay stage for start-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // A line back high at mid start bit is treated as a glitch.
                if (half_hit) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_hit && (idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt       = CNT_W'(cnt + CNT_W'(1));
        idx_nxt       = idx;
        shift_nxt     = shift;
        data_nxt      = data;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
        busy_nxt      = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = 3'd0;
            end
            DATA: begin
                if (bit_hit) begin
                    shift_nxt = {rx_s, shift[7:1]};
                    idx_nxt   = 3'(idx + 3'd1);
                    cnt_nxt   = '0;
                end
            end
            STOP: begin
                if (bit_hit) begin
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shift     <= shift_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= frame_err_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serial line driver feeds frames while a queue of expected
// outcomes (byte or framing error, plus launch cycle) is checked at every strobe.
module tb_uart_rx;

    localparam int unsigned BAUD = 10;
    localparam int unsigned F    = 160;
    localparam int unsigned DIV  = F / BAUD;
    localparam int unsigned HALF = DIV / 2;
    // Pin-to-strobe latency: HALF + 9 bits, plus two synchronizer cycles.
    localparam int unsigned LAT  = HALF + 9 * DIV + 2;

    typedef struct {
        bit          err;
        logic [7:0]  b;
        int unsigned t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned cyc        = 0;
    int unsigned pulses     = 0;
    int unsigned expected   = 0;
    logic [7:0]  last_good  = 8'h00;
    exp_t        exp_q[$];

    uart_rx #(.BAUD(BAUD), .F(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int unsigned clamp_lat(input int unsigned d);
        if (d < LAT - 2) return LAT - 2;
        if (d > LAT + 2) return LAT + 2;
        return d;
    endfunction

    // Strobe monitor: every pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t        e;
        int unsigned d;
        if (rst && (valid || frame_err)) begin
            pulses++;
            check("exclusive", 32'(valid & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                check("pulse_kind", 32'({frame_err, valid}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                d = cyc - e.t0;
                check("pulse_kind", 32'({frame_err, valid}), e.err ? 32'd2 : 32'd1);
                check("latency", d, clamp_lat(d));
                if (e.err) begin
                    check("data_hold", 32'(data), 32'(last_good));
                end else begin
                    check("data", 32'(data), 32'(e.b));
                    last_good = e.b;
                end
            end
        end
    end

    task automatic drive_line(input logic v, input int unsigned n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit err, input logic [7:0] b);
        exp_t e;
        e.err = err;
        e.b   = b;
        e.t0  = cyc;
        exp_q.push_back(e);
        expected++;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        push_exp(~stop, b);
        drive_line(1'b0, DIV);
        for (int i = 0; i < 8; i++) drive_line(b[i], DIV);
        drive_line(stop, DIV);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 12 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Short low pulse: busy must rise, then fall exactly HALF cycles later.
    task automatic glitch(input int unsigned w);
        int  rise = -1;
        int  fall = -1;
        rx = 1'b0;
        for (int i = 0; i < int'(3 * DIV); i++) begin
            if (i == int'(w)) rx = 1'b1;
            @(negedge clk);
            if (busy) begin
                if (rise < 0) rise = i;
            end else if (rise >= 0 && fall < 0) begin
                fall = i;
            end
        end
        rx = 1'b1;
        check("glitch_busy_rise", 32'(rise >= 0), 32'd1);
        check("glitch_busy_len", 32'(fall - rise), 32'(HALF));
    endtask

    initial begin
        logic [7:0]  b;
        logic        stop;
        int unsigned gap;

        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame.
        send(8'hAA, 1'b1);
        drive_line(1'b1, DIV);
        drain();
        check("aa_data", 32'(data), 32'hAA);

        // Back-to-back frames with zero idle gap.
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h5A, 1'b1);
        drive_line(1'b1, DIV);
        drain();

        // Glitch shorter than half a bit.
        glitch(HALF - 2);
        drive_line(1'b1, DIV);

        // Framing error, then a good frame.
        send(8'h3C, 1'b0);
        drive_line(1'b1, DIV);
        check("ferr_data_kept", 32'(data), 32'h5A);
        send(8'hC3, 1'b1);
        drive_line(1'b1, DIV);
        drain();

        // Break: one framing error, then idle while the line stays low.
        push_exp(1'b1, 8'h00);
        drive_line(1'b0, 20 * DIV);
        check("break_busy", 32'(busy), 32'd0);
        drive_line(1'b1, DIV);
        send(8'h81, 1'b1);
        drive_line(1'b1, DIV);
        drain();

        // Reset in the middle of a frame.
        b = 8'h96;
        drive_line(1'b0, DIV);
        for (int i = 0; i < 5; i++) drive_line(b[i], DIV);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 98; i++) begin
            check("in_reset_outputs", 32'({data, valid, frame_err, busy}), 32'd0);
            @(negedge clk);
        end
        last_good = 8'h00;
        rst = 1'b1;
        drive_line(1'b1, DIV);
        send(8'h69, 1'b1);
        drive_line(1'b1, DIV);
        drain();

        // Randomized traffic: bytes, stop-bit errors, gaps and glitches.
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send(b, stop);
            gap = stop ? $urandom_range(0, 2 * DIV) : $urandom_range(3, 2 * DIV);
            if (gap != 0) drive_line(1'b1, gap);
            if ($urandom_range(0, 5) == 0) begin
                drive_line(1'b1, 2);
                glitch($urandom_range(1, HALF - 2));
                drive_line(1'b1, 2);
            end
        end
        drive_line(1'b1, DIV);
        drain();
        check("pulse_total", pulses, expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
